// File: rtl/bf16_operand_issue.sv
// rtl/bf16_operand_issue.sv - bfloat16 operand FIFO with sanitising and classification on entry
// Triples are cleaned up at push time so the ALU only ever sees canonical operands.
module bf16_operand_issue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [15:0]   in_a,
  input  logic [15:0]   in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_op,
  output logic [15:0]   out_a,
  output logic [15:0]   out_b,
  output logic [2:0]    out_cls_a,
  output logic [2:0]    out_cls_b,
  output logic [CW-1:0] count,
  output logic          illegal_op,
  output logic          nan_seen
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] CLS_NORM = 3'b000;
  localparam logic [2:0] CLS_ZERO = 3'b001;
  localparam logic [2:0] CLS_INF  = 3'b011;
  localparam logic [2:0] CLS_NAN  = 3'b100;

  // Returns {class, sanitised value}. A zero exponent always yields a signed zero,
  // which covers both true zeros and flushed subnormals.
  function automatic logic [18:0] sanitise(input logic [15:0] x);
    logic [18:0] r;
    if (x[14:7] == 8'h00)
      r = {CLS_ZERO, x[15], 15'h0000};
    else if (x[14:7] == 8'hFF)
      r = (x[6:0] == 7'h00) ? {CLS_INF, x} : {CLS_NAN, 16'h7FC0};
    else
      r = {CLS_NORM, x};
    return r;
  endfunction

  // Entry layout: {op[39:38], a[37:22], b[21:6], cls_a[5:3], cls_b[2:0]}
  logic [39:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [18:0]   san_a;
  logic [18:0]   san_b;
  logic [39:0]   head;
  logic          push;
  logic          pop;
  logic          store;
  logic          reserved;

  assign san_a    = sanitise(in_a);
  assign san_b    = sanitise(in_b);
  assign reserved = (in_op == 2'b11);

  assign in_ready  = (count < CW'(DEPTH)) & ~flush;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign store     = push & ~reserved;
  assign pop       = out_valid & out_ready & ~flush;

  assign head      = mem[rd_ptr];
  assign out_op    = out_valid ? head[39:38] : 2'b00;
  assign out_a     = out_valid ? head[37:22] : 16'h0000;
  assign out_b     = out_valid ? head[21:6]  : 16'h0000;
  assign out_cls_a = out_valid ? head[5:3]   : 3'b000;
  assign out_cls_b = out_valid ? head[2:0]   : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      illegal_op <= 1'b0;
      nan_seen   <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      illegal_op <= 1'b0;
      nan_seen   <= 1'b0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= {in_op, san_a[15:0], san_b[15:0], san_a[18:16], san_b[18:16]};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(store) - CW'(pop);
      if (push && reserved)
        illegal_op <= 1'b1;
      // Discarded reserved triples never reach storage, so they cannot flag a NaN.
      if (store && (san_a[18:16] == CLS_NAN || san_b[18:16] == CLS_NAN))
        nan_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bf16_operand_issue.sv
// tb/tb_bf16_operand_issue.sv - randomized self-checking bench for bf16_operand_issue
// A queue-based model of the FIFO and flags tracks the expected state cycle by cycle.
module tb_bf16_operand_issue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = 2'b00;
  logic [15:0]   in_a = 16'h0;
  logic [15:0]   in_b = 16'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_op;
  logic [15:0]   out_a;
  logic [15:0]   out_b;
  logic [2:0]    out_cls_a;
  logic [2:0]    out_cls_b;
  logic [CW-1:0] count;
  logic          illegal_op;
  logic          nan_seen;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  ca;
    logic [2:0]  cb;
  } entry_t;

  entry_t mq[$];
  logic   m_ill = 1'b0;
  logic   m_nan = 1'b0;

  bf16_operand_issue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_a(out_a), .out_b(out_b),
    .out_cls_a(out_cls_a), .out_cls_b(out_cls_b), .count(count),
    .illegal_op(illegal_op), .nan_seen(nan_seen)
  );

  always #5 clk = ~clk;

  // Classification by magnitude ranges of the 15-bit unsigned part.
  task automatic model_san(input logic [15:0] x, output logic [15:0] v, output logic [2:0] c);
    logic [14:0] mag;
    mag = x[14:0];
    if (mag == 15'h0)          begin v = x;                  c = 3'b001; end
    else if (mag < 15'h0080)   begin v = {x[15], 15'h0};     c = 3'b001; end
    else if (mag == 15'h7F80)  begin v = x;                  c = 3'b011; end
    else if (mag > 15'h7F80)   begin v = 16'h7FC0;           c = 3'b100; end
    else                       begin v = x;                  c = 3'b000; end
  endtask

  // Applies one cycle of stimulus and advances the model; leaves time at posedge+1.
  task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ordy, input logic fl);
    bit push, pop;
    entry_t e;
    in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = ordy; flush = fl;
    push = v && (mq.size() < DEPTH) && !fl;
    pop  = (mq.size() != 0) && ordy && !fl;
    @(posedge clk); #1;
    if (fl) begin
      mq.delete(); m_ill = 1'b0; m_nan = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (op == 2'b11) m_ill = 1'b1;
        else begin
          e.op = op;
          model_san(a, e.a, e.ca);
          model_san(b, e.b, e.cb);
          mq.push_back(e);
          if (e.ca == 3'b100 || e.cb == 3'b100) m_nan = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [15:0] rnd_bf();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 5))
      0: r = {r[15], 15'h0};
      1: r = {r[15], 8'h00, r[6:0] | 7'h01};
      2: r = {r[15], 15'h7F80};
      3: r = {r[15], 8'hFF, r[6:0] | 7'h01};
      default: ;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({out_valid, count, illegal_op, nan_seen, out_op, out_a, out_b, out_cls_a, out_cls_b} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: out_valid=%b count=%0d ill=%b nan=%b a=%h b=%h required all zero",
               out_valid, count, illegal_op, nan_seen, out_a, out_b);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_first_push();
    drive(1'b1, 2'b10, 16'h3F80, 16'h4000, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if ({out_valid, count, out_op, out_a, out_b, out_cls_a, out_cls_b} !==
        {1'b1, 3'd1, 2'b10, 16'h3F80, 16'h4000, 3'b000, 3'b000}) begin
      failures++;
      $display("FAIL first_push: valid=%b count=%0d op=%b a=%h b=%h ca=%b cb=%b required 1 1 10 3f80 4000 000 000",
               out_valid, count, out_op, out_a, out_b, out_cls_a, out_cls_b);
    end
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(i % 3), 16'h3F80 + 16'(i), 16'h4100 + 16'(i), 1'b0, 1'b0);
      checks++;
      if (in_ready !== (i < 3) || count !== CW'(mq.size())) begin
        failures++;
        $display("FAIL fill_%0d: in_ready=%b count=%0d required %b %0d", i, in_ready, count, (i < 3), mq.size());
      end
    end
    checks++;
    if (count !== 3'd4) begin
      failures++;
      $display("FAIL fill_full: count=%0d required 4", count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_a !== 16'h3F80 + 16'(i) || out_b !== 16'h4100 + 16'(i) || out_op !== 2'(i % 3)) begin
        failures++;
        $display("FAIL drain_%0d: valid=%b op=%b a=%h b=%h required 1 %b %h %h", i, out_valid, out_op,
                 out_a, out_b, 2'(i % 3), 16'h3F80 + 16'(i), 16'h4100 + 16'(i));
      end
      drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
    end
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: count=%0d valid=%b required 0 0", count, out_valid);
    end
  endtask

  task automatic test_stream();
    drive(1'b1, 2'b00, 16'h3F00, 16'h4000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'b01, 16'h3F80 + 16'(i), 16'hC000 + 16'(i), 1'b1, 1'b0);
      checks++;
      if (count !== 3'd1 || out_valid !== 1'b1 || out_a !== mq[0].a || out_b !== mq[0].b || out_a !== 16'h3F80 + 16'(i)) begin
        failures++;
        $display("FAIL stream_%0d: count=%0d a=%h b=%h required 1 %h %h", i, count, out_a, out_b, mq[0].a, mq[0].b);
      end
    end
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic test_sanitise();
    drive(1'b1, 2'b00, 16'h0045, 16'hFFA1, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 16'h8001, 16'h7F80, 1'b0, 1'b0);
    checks++;
    if ({out_a, out_cls_a, out_b, out_cls_b, nan_seen} !== {16'h0000, 3'b001, 16'h7FC0, 3'b100, 1'b1}) begin
      failures++;
      $display("FAIL sanitise_1: a=%h ca=%b b=%h cb=%b nan=%b required 0000 001 7fc0 100 1",
               out_a, out_cls_a, out_b, out_cls_b, nan_seen);
    end
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
    checks++;
    if ({out_a, out_cls_a, out_b, out_cls_b} !== {16'h8000, 3'b001, 16'h7F80, 3'b011}) begin
      failures++;
      $display("FAIL sanitise_2: a=%h ca=%b b=%h cb=%b required 8000 001 7f80 011", out_a, out_cls_a, out_b, out_cls_b);
    end
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reserved_flush();
    drive(1'b1, 2'b11, 16'h3F80, 16'h3F80, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || illegal_op !== 1'b1 || nan_seen !== 1'b1) begin
      failures++;
      $display("FAIL reserved: count=%0d valid=%b ill=%b nan=%b required 0 0 1 1", count, out_valid, illegal_op, nan_seen);
    end
    drive(1'b1, 2'b00, 16'h3F80, 16'h3F80, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 16'h7FFF, 16'h3F80, 1'b1, 1'b1);
    checks++;
    if (count !== 3'd0 || illegal_op !== 1'b0 || nan_seen !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush: count=%0d ill=%b nan=%b valid=%b required 0 0 0 0", count, illegal_op, nan_seen, out_valid);
    end
  endtask

  task automatic test_random();
    logic fl;
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(0, 39) == 0);
      drive(1'($urandom), 2'($urandom), rnd_bf(), rnd_bf(), 1'($urandom), fl);
      checks++;
      if (count !== CW'(mq.size()) || out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < DEPTH && !fl)
          || illegal_op !== m_ill || nan_seen !== m_nan) begin
        failures++;
        $display("FAIL random_state_%0d: count=%0d valid=%b rdy=%b ill=%b nan=%b required %0d %b %b %b %b", i, count,
                 out_valid, in_ready, illegal_op, nan_seen, mq.size(), mq.size() != 0, mq.size() < DEPTH && !fl, m_ill, m_nan);
      end
      if (mq.size() != 0) begin
        checks++;
        if ({out_op, out_a, out_b, out_cls_a, out_cls_b} !== mq[0]) begin
          failures++;
          $display("FAIL random_head_%0d: op=%b a=%h b=%h ca=%b cb=%b required %b %h %h %b %b", i, out_op, out_a, out_b,
                   out_cls_a, out_cls_b, mq[0].op, mq[0].a, mq[0].b, mq[0].ca, mq[0].cb);
        end
      end
    end
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b00, 16'h4000 + 16'(i), 16'h3F80, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd3) begin
      failures++;
      $display("FAIL async_prefill: count=%0d required 3", count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL async_reset: valid=%b count=%0d required 0 0", out_valid, count);
    end
    mq.delete(); m_ill = 1'b0; m_nan = 1'b0;
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || count !== 3'd0) begin
      failures++;
      $display("FAIL async_recover: rdy=%b count=%0d required 1 0", in_ready, count);
    end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_fill();
    test_stream();
    test_sanitise();
    test_reserved_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bf16_operand_issue.md
Name: bf16_operand_issue

Overview:
Upstream issue stage for bfloat_alu. Buffers {opcode, operand A, operand B} triples from a producer in a small FIFO and sanitises each bfloat16 operand on entry: subnormals flushed to zero, NaNs canonicalised. Each operand is classified on entry and the triple is presented to the ALU with a valid/ready handshake. This decouples operand generation from ALU throughput.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2.
CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of FIFO and sticky flags
in_valid  input  1  producer offers a triple
in_ready  output  1  block can accept a triple this cycle
in_op  input  2  00 add, 01 sub, 10 mul, 11 reserved
in_a  input  16  operand A, bfloat16 (1 sign / 8 exponent / 7 mantissa)
in_b  input  16  operand B, bfloat16
out_valid  output  1  head triple presented to ALU
out_ready  input  1  ALU accepts head triple
out_op  output  2  head opcode
out_a  output  16  head operand A, sanitised
out_b  output  16  head operand B, sanitised
out_cls_a  output  3  class of out_a
out_cls_b  output  3  class of out_b
count  output  CW  occupied entries, 0..DEPTH
illegal_op  output  1  sticky: a reserved opcode was received
nan_seen  output  1  sticky: a NaN operand was accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: while rst_n = 0, all outputs and state are cleared: FIFO empty, count = 0, out_valid = 0, out_op/out_a/out_b/out_cls_* = 0, illegal_op = 0, nan_seen = 0. in_ready = 1 from the first cycle after deassertion.
- Reset asserted mid-operation discards all entries immediately (asynchronous).
- Push: occurs when in_valid & in_ready. Pop: occurs when out_valid & out_ready.
- in_ready = (count < DEPTH) & ~flush. It has no combinational path from out_ready, so a full FIFO does not accept a push even in a cycle where it pops.
- out_valid = (count != 0). Head fields are driven from registered storage and are held stable while out_valid & ~out_ready.
- Latency: a push into an empty FIFO appears at the outputs on the next cycle.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- count: +1 on push only, -1 on pop only, unchanged when push and pop occur in the same cycle.
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Sanitising, applied per operand at push (exponent e = bits[14:7], mantissa m = bits[6:0]):
  - e = 0, m = 0: stored unchanged, class 001 (zero).
  - e = 0, m != 0: stored as {sign, 15'h0000}, class 001 (flush-to-zero, sign kept).
  - e = FF, m = 0: stored unchanged, class 011 (infinity).
  - e = FF, m != 0: stored as 16'h7FC0, class 100 (NaN); sets nan_seen.
  - otherwise: stored unchanged, class 000 (normal).
  - Codes 010 and 101-111 are unused.
- Reserved opcode 11: the push handshake completes (in_ready honoured) but the triple is not stored. count is unchanged and illegal_op is set. nan_seen is not affected by a discarded triple.
- flush = 1: at the next edge, pointers = 0, count = 0 and both sticky flags = 0. Any same-cycle pop is void; no push occurs because in_ready = 0.
- Simultaneous push and pop at count = 1: the new triple becomes head on the next cycle and count stays 1.
- Sticky flags hold until flush or reset. The set condition has priority over hold; flush has priority over set.

Test Plan:
- Reset and first push: rst_n low, then high; push {10, 3F80, 4000} with out_ready = 0 -> next cycle out_valid = 1, out_a = 3F80, out_b = 4000, cls 000/000, count = 1.
- Fill and backpressure: DEPTH = 4, out_ready = 0, push 5 triples back-to-back -> in_ready = 0 after the 4th, 5th not accepted, count = 4. Then out_ready = 1 -> 4 pops in push order and count returns to 0.
- Streaming: in_valid = out_ready = 1 for 20 cycles with incrementing operands -> one pop per cycle, order preserved across pointer wrap, count steady.
- Sanitise: push a = 0045, b = FFA1 -> out_a = 0000, cls 001; out_b = 7FC0, cls 100; nan_seen = 1. Push a = 8001 -> out_a = 8000. Push b = 7F80 -> cls 011.
- Reserved opcode: push {11, 3F80, 3F80} -> count unchanged, illegal_op = 1, nothing presented. Then flush for 1 cycle -> count = 0, illegal_op = 0, nan_seen = 0.
- Asynchronous reset: with 3 entries queued, pulse rst_n low between clock edges -> out_valid = 0 and count = 0 immediately, without waiting for a clock edge.
